// File: rtl/pa_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : pa_ram_loader
// Purpose  : Streams 32-bit packed weight words into the 16-bank pa_ram.
//            It fills banks 0..BANKS-1 with N = ceil(rhs_cols/4) words each,
//            then pulses done.
// Options  : PA_LOADER_BSWAP_EN - byte-reverse each word for big-endian sources
// Revision : 1.0 - initial release
// ============================================================================
module pa_ram_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int BANKS      = 16,
  parameter int BANK_WORDS = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             rhs_cols,
  input  logic [4*DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [4*DATA_WIDTH-1:0] ram_data,
  output logic                    ram_we,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int WORD_W = $clog2(BANK_WORDS);
  localparam int BANK_W = $clog2(BANKS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state, state_nxt;
  logic [WORD_W-1:0]       word, n_last;
  logic [BANK_W-1:0]       bank;
  logic [32:0]             n_words;
  logic                    cfg_ok;
  logic                    beat;
  logic                    word_end;
  logic                    last_beat;
  logic [4*DATA_WIDTH-1:0] data_in;

  // Words per bank in 33 bits so rhs_cols near 2^32 cannot wrap to a small N.
  assign n_words   = ({1'b0, rhs_cols} + 33'd3) >> 2;
  assign cfg_ok    = (n_words != 33'd0) && (n_words <= 33'(BANK_WORDS));
  assign beat      = s_valid && s_ready;
  assign word_end  = (word == n_last);
  assign last_beat = word_end && (bank == BANK_W'(BANKS - 1));

  // Optional byte reversal of each stream word before it reaches the RAM.
  always_comb begin
    data_in = s_data;
`ifdef PA_LOADER_BSWAP_EN
    for (int i = 0; i < 4; i++) begin
      data_in[i*DATA_WIDTH +: DATA_WIDTH] = s_data[(3-i)*DATA_WIDTH +: DATA_WIDTH];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a bad configuration keeps the loader in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_nxt = S_LOAD;
      S_LOAD:  if (beat && last_beat) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_LOAD:  begin s_ready = 1'b1; busy = 1'b1; end
      S_FLUSH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Configuration latch, sticky error and bank/word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      n_last <= '0;
      bank   <= '0;
      word   <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        err <= !cfg_ok;
        if (cfg_ok) begin
          n_last <= WORD_W'(n_words - 33'd1);
          bank   <= '0;
          word   <= '0;
        end
      end
    end else if (beat) begin
      if (word_end) begin
        word <= '0;
        bank <= bank + 1'b1;
      end else begin
        word <= word + 1'b1;
      end
    end
  end

  // Registered RAM write port; address and data hold when no beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= beat;
      if (beat) begin
        ram_addr <= ADDR_WIDTH'({bank, word});
        ram_data <= data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pa_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_ram_loader
// Purpose  : Scoreboard bench for pa_ram_loader with randomized stream gaps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_ram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rhs_cols = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  wire         s_ready, ram_we, busy, done, err;
  wire  [12:0] ram_addr;
  wire  [31:0] ram_data;

  always #5 clk = ~clk;

  pa_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .rhs_cols(rhs_cols),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [12:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  logic prev_beat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word as pa_ram should store it.
  function automatic logic [31:0] model_data(input logic [31:0] d);
`ifdef PA_LOADER_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Monitor: every write must follow an accepted beat and match the queue head.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      chk("we_in_reset", {31'd0, ram_we}, 32'd0);
      exp_q.delete();
      prev_beat = 1'b0;
    end else begin
      chk("we_timing", {31'd0, ram_we}, {31'd0, prev_beat});
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ram_addr", {19'd0, ram_addr}, {19'd0, e.a});
          chk("ram_data", ram_data, e.d);
          n_writes++;
        end
      end
      prev_beat = s_valid && s_ready;
    end
  end

  // One load. vmode: 0 valid held, 1 toggling, 2 random. dmode: 0 random,
  // 1 incrementing from 1, 2 fixed 0x11223344. abort_at>0 resets after that
  // many beats; poke issues a bad start mid-load that must be ignored.
  task automatic run_load(input int cols, input int vmode, input int dmode,
                          input int abort_at, input bit poke);
    int  n;
    int  total;
    int  k;
    int  cyc;
    int  budget;
    wr_t e;
    n      = (cols + 3) / 4;
    total  = 16 * n;
    k      = 0;
    cyc    = 0;
    budget = total * 4 + 50;
    n_writes = 0;
    @(posedge clk); #1;
    start    = 1'b1;
    rhs_cols = cols;
    s_valid  = 1'b1;
    s_data   = (dmode == 1) ? 32'd1 : (dmode == 2) ? 32'h1122_3344 : $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    forever begin
      if (s_valid && s_ready) begin
        e.a = 13'(((k / n) << 9) | (k % n));
        e.d = model_data(s_data);
        exp_q.push_back(e);
        k++;
        if (k == total || k == abort_at) break;
      end
      cyc++;
      if (cyc > budget) begin
        chk("beat_timeout", k, total);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (poke && cyc == 3) begin
        start    = 1'b1;
        rhs_cols = 32'd0;
      end
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = ~s_valid;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = (dmode == 1) ? 32'(k + 1) : (dmode == 2) ? 32'h1122_3344 : $urandom;
      @(negedge clk);
    end
    if (k == abort_at) begin
      @(posedge clk); #1;
      rst     = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_addr", {19'd0, ram_addr}, 32'd0);
      chk("abort_data", ram_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    // Keep offering data past the last beat; it must not be consumed.
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = $urandom;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("write_count", n_writes, total);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("err_after_load", {31'd0, err}, 32'd0);
  endtask

  // Rejected configuration: err set, nothing else moves.
  task automatic bad_start(input logic [31:0] cols);
    @(posedge clk); #1;
    start    = 1'b1;
    rhs_cols = cols;
    s_valid  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bad_busy", {31'd0, busy}, 32'd0);
      chk("bad_done", {31'd0, done}, 32'd0);
      chk("bad_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bad_err", {31'd0, err}, 32'd1);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", {19'd0, ram_addr}, 32'd0);
      chk("rst_data", ram_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    run_load(8, 0, 1, 0, 1'b0);
    run_load(5, 1, 0, 0, 1'b1);
    bad_start(32'd0);
    bad_start(32'd2049);
    bad_start(32'hFFFF_FFFF);
    run_load(4, 0, 2, 0, 1'b0);
    run_load(2048, 0, 0, 0, 1'b0);
    run_load(2045, 2, 0, 0, 1'b0);
    run_load(16, 2, 0, 10, 1'b0);
    run_load(16, 0, 1, 0, 1'b0);
    run_load(13, 2, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pa_ram_loader.md
Name: pa_ram_loader

Overview:
- Upstream feeder for the 16-bank weight RAM (pa_ram).
- Accepts a stream of 32-bit packed weight words over a valid/ready handshake.
- Generates the bank-coded write address and write strobe for pa_ram: bank in addr[12:9], word in addr[8:0].
- Fills banks 0..15 in order, then pulses done, after which pa_ram may be read.

Parameters:
- ADDR_WIDTH, 13, pa_ram address width; upper 4 bits = bank, lower 9 bits = word.
- DATA_WIDTH, 8, element width; a stream word carries 4 elements.
- BANKS, 16, number of banks (channels) filled per load.
- BANK_WORDS, 512, 32-bit word depth of each bank.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle load request; sampled only in IDLE.
- rhs_cols  input  32  elements per bank; sampled on accepted start.
- s_data  input  4*DATA_WIDTH  weight word; element 0 in bits [7:0].
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data this cycle.
- ram_addr  output  ADDR_WIDTH  pa_ram addr = {bank[3:0], word[8:0]}.
- ram_data  output  4*DATA_WIDTH  pa_ram data_in.
- ram_we  output  1  pa_ram write enable.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last write.
- err  output  1  sticky config error; cleared by next accepted start or rst.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. An asserted rst aborts any load immediately; no further ram_we.
- words_per_bank N = ceil(rhs_cols/4) = (rhs_cols+3)>>2, computed in 33 bits with no overflow.
- States:
  - IDLE: s_ready=0, ram_we=0. On start:
    - If N==0 or N>BANK_WORDS: set err=1, stay IDLE, busy stays 0, no done.
    - Else: latch N, clear err, bank=0, word=0, busy=1, go LOAD.
  - LOAD: s_ready=1. Beat accepted when s_valid && s_ready. Next cycle: ram_we=1, ram_data=s_data, ram_addr={bank,word} (registered; 1-cycle latency). Counter update: word++; if word==N-1 then word=0 and bank++. On the beat with bank==BANKS-1 && word==N-1, go FLUSH; s_ready drops the next cycle.
  - FLUSH: last registered write is on the bus this cycle (ram_we=1); go DONE.
  - DONE: done=1 and busy=0 for one cycle; ram_we=0; go IDLE.
- Without a beat, ram_we=0 next cycle; ram_addr and ram_data hold their last values. In IDLE/DONE, ram_we is guaranteed 0 so pa_ram is in read mode.
- s_valid gaps are allowed at any point; the counters do not advance.
- start during LOAD/FLUSH/DONE is ignored; no restart and err is unchanged.
- Total accepted beats = BANKS*N exactly. Extra s_valid after that sees s_ready=0 and is not consumed.
- N==BANK_WORDS (rhs_cols 2045..2048): word wraps 511→0 correctly; no write reaches the next bank early.
- Bytes of a trailing partial word (rhs_cols%4 != 0) are written as supplied; padding is the source's job.

Optional Feature:
- Macro PA_LOADER_BSWAP_EN.
- Defined: ram_data is s_data byte-reversed per word (bits [7:0]↔[31:24], [15:8]↔[23:16]), for big-endian sources.
- Undefined: ram_data = s_data unchanged.
- Latency, handshake and address sequence are identical in both builds.

Test Plan:
- rhs_cols=8, s_valid held high, s_data=incrementing from 0x0000_0001 → 32 writes at addr 0x0000,0x0001,0x0200,0x0201,...,0x1E01. done pulses 2 cycles after the 32nd beat; busy is 0 in the same cycle.
- rhs_cols=5 (N=2) with s_valid toggling 1/0 each cycle → still exactly 32 writes, in order. ram_we never high in cycles following a gap.
- rhs_cols=0, then separately rhs_cols=2049 → err=1, busy stays 0, no ram_we, no done. Next start with rhs_cols=4 clears err and completes 16 writes at addr 0x0000,0x0200,...,0x1E00.
- rhs_cols=2048 → bank 0 gets words 0..511; write 513 lands at addr 0x0200. Last write at 0x1FFF.
- rst asserted after 10 beats of a rhs_cols=16 load → outputs 0 immediately. A new start then restarts from addr 0x0000.
- PA_LOADER_BSWAP_EN defined, s_data=0x1122_3344 → ram_data=0x4433_2211. Undefined → ram_data=0x1122_3344.
